// File: rtl/instr_fetch.sv
// Fetch stage: owns the program counter, addresses the program ROM directly,
// and registers the returned instruction (with its address) toward decode
// over a valid/ready handshake. Handles start, stall, jump/flush and
// end-of-program, and latches a sticky fault on an out-of-range jump.
module instr_fetch #(
  parameter logic [15:0] RESET_ADDR = 16'd0,
  parameter logic [15:0] PROG_LEN   = 16'd11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  output logic [15:0] o_rom_addr,
  input  logic [17:0] i_rom_instr,
  output logic [17:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr,
  output logic        o_done,
  output logic        o_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [17:0] instr_q;
  logic [15:0] opc_q;
  logic        valid_q;
  logic        fault_q;

  logic        slot_free;
  logic        fire;
  logic        jump_ok;
  logic        at_last;
  logic [15:0] pc_d;

  // Handshake terms and the sequential pc successor (16-bit wrap is natural).
  assign slot_free = !valid_q || i_ready;
  assign fire      = valid_q && i_ready;
  assign jump_ok   = (i_jump_addr < PROG_LEN);
  assign at_last   = (pc_q == PROG_LEN - 16'd1);
  assign pc_d      = pc_q + 16'd1;

  assign o_rom_addr = pc_q;
  assign o_instr    = instr_q;
  assign o_pc       = opc_q;
  assign o_valid    = valid_q;
  assign o_done     = (state_q == ST_DONE);
  assign o_fault    = fault_q;

  // Fetch FSM: pc, output register, valid flag and sticky fault.
  // NOTE: every register here is assigned with <= so all updates in a cycle
  // see the pre-edge values; mixing = into this block would create order
  // dependent behaviour between pc_q and the captured opc_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_ADDR;
      instr_q <= 18'd0;
      opc_q   <= 16'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A jump while idle only repositions the start address; an
          // out-of-range target is ignored so it can never be fetched.
          if (i_jump && jump_ok) pc_q <= i_jump_addr;
          if (fire) valid_q <= 1'b0;
          if (i_run) state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (i_jump) begin
            // Flush wins over both the handshake and a new fetch.
            valid_q <= 1'b0;
            if (jump_ok) begin
              pc_q <= i_jump_addr;
            end else begin
              fault_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end else if (slot_free) begin
            instr_q <= i_rom_instr;
            opc_q   <= pc_q;
            valid_q <= 1'b1;
            if (at_last) state_q <= ST_DONE;
            else         pc_q    <= pc_d;
          end
        end

        ST_DONE: begin
          if (i_jump) begin
            valid_q <= 1'b0;
            if (jump_ok) begin
              pc_q    <= i_jump_addr;
              state_q <= ST_RUN;
            end else begin
              fault_q <= 1'b1;
            end
          end else if (fire) begin
            // Last instruction drains; nothing new is fetched.
            valid_q <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of per-cycle input/expected-output
// records plus a hand-written async-reset / idle sequence.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] rom_addr;
  logic [17:0] rom_instr;
  logic [17:0] instr;
  logic [15:0] pc;
  logic        valid;
  logic        ready;
  logic        jump;
  logic [15:0] jump_addr;
  logic        done;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  // Program image; entries past word 10 are never legally fetched.
  localparam logic [17:0] ROM [16] = '{
    18'h0000E, 18'h32800, 18'h31000, 18'h20C01, 18'h3A400, 18'h1F0F0,
    18'h0A5A5, 18'h2B3C4, 18'h15555, 18'h3C3C3, 18'h0FFFF,
    18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF
  };

  assign rom_instr = (rom_addr < 16'd11) ? ROM[rom_addr[3:0]] : 18'h3FFFF;

  instr_fetch #(.RESET_ADDR(16'd0), .PROG_LEN(16'd11)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (run),
    .o_rom_addr  (rom_addr),
    .i_rom_instr (rom_instr),
    .o_instr     (instr),
    .o_pc        (pc),
    .o_valid     (valid),
    .i_ready     (ready),
    .i_jump      (jump),
    .i_jump_addr (jump_addr),
    .o_done      (done),
    .o_fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        ready;
    logic        jump;
    logic [15:0] jaddr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [17:0] e_instr;
    logic [15:0] e_addr;
    logic        e_done;
    logic        e_fault;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic j,
                              input logic [15:0] ja, input logic ev,
                              input logic [15:0] epc, input logic [17:0] ei,
                              input logic [15:0] ea, input logic ed,
                              input logic ef);
    vec_t v;
    v.run = r; v.ready = rdy; v.jump = j; v.jaddr = ja;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ei; v.e_addr = ea;
    v.e_done = ed; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev,
                           input logic [15:0] epc, input logic [17:0] ei,
                           input logic [15:0] ea, input logic ed,
                           input logic ef);
    check({tag, "_valid"}, 32'(valid),    32'(ev));
    check({tag, "_pc"},    32'(pc),       32'(epc));
    check({tag, "_instr"}, 32'(instr),    32'(ei));
    check({tag, "_addr"},  32'(rom_addr), 32'(ea));
    check({tag, "_done"},  32'(done),     32'(ed));
    check({tag, "_fault"}, 32'(fault),    32'(ef));
  endtask

  task automatic drive(input logic r, input logic rdy, input logic j,
                       input logic [15:0] ja);
    run = r; ready = rdy; jump = j; jump_addr = ja;
  endtask

  initial begin
    // Start from IDLE: one edge to enter RUN, then 0..10 back to back.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 18'd0, 0, 0, 0));
    for (int k = 0; k <= 10; k++)
      tbl.push_back(mk(1, 1, 0, 0, 1, 16'(k), ROM[k],
                       (k < 10) ? 16'(k + 1) : 16'd10, (k == 10), 0));
    // Last instruction drains; valid drops, done stays.
    tbl.push_back(mk(1, 1, 0, 0, 0, 10, ROM[10], 10, 1, 0));
    // Jump out of DONE to 3, resume 3, 4.
    tbl.push_back(mk(1, 1, 1, 3, 0, 10, ROM[10], 3, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 3, ROM[3], 4, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 4, ROM[4], 5, 0, 0));
    // Stall three cycles on pc 4, then 5, 6, 7 with no skip or repeat.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 4, 18'h3A400, 5, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 5, ROM[5], 6, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 6, ROM[6], 7, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 7, ROM[7], 8, 0, 0));
    // Jump to 2 with a live instruction: flush bubble, then target.
    tbl.push_back(mk(1, 1, 1, 2, 0, 7, ROM[7], 2, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 2, 18'h31000, 3, 0, 0));
    // Bad jump: fault + DONE, pc unchanged; fault survives a good jump.
    tbl.push_back(mk(1, 1, 1, 20, 0, 2, ROM[2], 3, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, ROM[2], 3, 1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, ROM[2], 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, ROM[0], 1, 0, 1));

    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].run, tbl[i].ready, tbl[i].jump, tbl[i].jaddr);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), tbl[i].e_valid, tbl[i].e_pc,
                tbl[i].e_instr, tbl[i].e_addr, tbl[i].e_done,
                tbl[i].e_fault);
    end

    // Stall on pc 0, then async reset between edges.
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(posedge clk); #1;
    check_all("stall", 1, 0, ROM[0], 1, 0, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE holds with run low.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_all($sformatf("idle%0d", k), 0, 0, 0, 0, 0, 0);
    end

    // Jump while idle repositions pc only; run then starts from it.
    @(negedge clk);
    drive(0, 1, 1, 5);
    @(posedge clk); #1;
    check_all("idle_jump", 0, 0, 0, 5, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 0);
    @(posedge clk); #1;
    check_all("start", 0, 0, 0, 5, 0, 0);
    @(posedge clk); #1;
    check_all("first", 1, 5, ROM[5], 6, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
